// File: rtl/rv_pkg.sv
// Shared RV32I integer-file definitions: default widths and register/data types.
// Blocks that need other sizes override these defaults through their own parameters.
package rv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xlen_t;

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Bus between the ID stage and the register file: operand reads, write-back and issue tracking.
// The master side is the pipeline; the slave side is the register file.
interface regfile_mp_sb_if #(
    parameter int XLEN = rv_pkg::XLEN,
    parameter int AW   = rv_pkg::AW,
    parameter int NRD  = 2,
    parameter int CW   = $clog2(rv_pkg::NREGS + 1)
);
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rd_busy;
    logic                stall;
    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic                issue_en;
    logic [AW-1:0]       issue_rd;
    logic                flush;
    logic [CW-1:0]       pend_cnt;

    modport master (
        output ra, we, wa, wd, issue_en, issue_rd, flush,
        input  rd, rd_busy, stall, pend_cnt
    );

    modport slave (
        input  ra, we, wa, wd, issue_en, issue_rd, flush,
        output rd, rd_busy, stall, pend_cnt
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Pending-destination tracker: flush beats write-back clear, and an issue to the same register
// as a write-back wins so the newer producer stays outstanding.
module rf_scoreboard #(
    parameter int  NREGS = rv_pkg::NREGS,
    localparam int AW    = $clog2(NREGS),
    localparam int CW    = $clog2(NREGS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_rd,
    input  logic             flush,
    output logic [NREGS-1:0] pending,
    output logic [CW-1:0]    pend_cnt
);

    logic [NREGS-1:0] pend_d;
    logic [CW-1:0]    cnt_d;
    logic             do_clr;
    logic             do_set;
    logic             inc;
    logic             dec;

    always_comb begin
        pend_d = pending;
        cnt_d  = pend_cnt;
        do_clr = we && (wa != '0);
        do_set = issue_en && (issue_rd != '0);
        inc    = do_set && !pending[issue_rd];
        // a clear that collides with a set on the same register is cancelled
        dec    = do_clr && pending[wa] && !(do_set && (issue_rd == wa));
        if (flush) begin
            pend_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_clr) pend_d[wa] = 1'b0;
            if (do_set) pend_d[issue_rd] = 1'b1;
            cnt_d = pend_cnt + CW'(inc) - CW'(dec);
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= pend_d;
            pend_cnt <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port integer register file with x0 hardwired to zero, optional write-first bypass
// and a write-back scoreboard that flags operands whose producer has not yet written back.
module regfile_mp_sb #(
    parameter int XLEN   = rv_pkg::XLEN,
    parameter int NREGS  = rv_pkg::NREGS,
    parameter int NRD    = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    regfile_mp_sb_if.slave bus
);

    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS + 1);

    logic [XLEN-1:0]     regs [NREGS];
    logic [NREGS-1:0]    pending;
    logic [CW-1:0]       pend_cnt;
    logic [NRD*XLEN-1:0] rd_vec;
    logic [NRD-1:0]      busy_vec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (bus.we && (bus.wa != '0)) begin
            regs[bus.wa] <= bus.wd;
        end
    end

    rf_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .we       (bus.we),
        .wa       (bus.wa),
        .issue_en (bus.issue_en),
        .issue_rd (bus.issue_rd),
        .flush    (bus.flush),
        .pending  (pending),
        .pend_cnt (pend_cnt)
    );

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            hit;
        logic [XLEN-1:0] rd_word;

        assign addr = bus.ra[g*AW +: AW];
        assign hit  = BYPASS && bus.we && (bus.wa == addr);

        // outputs are forced quiet while reset is held, even if a bypass would match
        always_comb begin
            rd_word = '0;
            if (rst && (addr != '0)) rd_word = hit ? bus.wd : regs[addr];
        end

        assign rd_vec[g*XLEN +: XLEN] = rd_word;
        assign busy_vec[g]            = rst && pending[addr] && !hit;
    end

    assign bus.rd       = rd_vec;
    assign bus.rd_busy  = busy_vec;
    assign bus.stall    = |busy_vec;
    assign bus.pend_cnt = pend_cnt;

endmodule
